// File: rtl/adc_spi_sampler_if.sv
// Bus bundle between the ADC sampler and its environment:
// enable and serial data in, chip select, SCLK and the sample strobe out.
interface adc_spi_sampler_if #(
    parameter int ADC_DATLEN = 12
);
    logic                  en;
    logic                  adc_miso;
    logic                  adc_cs_n;
    logic                  adc_sclk;
    logic [ADC_DATLEN-1:0] sample;
    logic                  rdy;
    logic                  overrun;

    modport master (
        input  en, adc_miso,
        output adc_cs_n, adc_sclk, sample, rdy, overrun
    );

    modport slave (
        output en, adc_miso,
        input  adc_cs_n, adc_sclk, sample, rdy, overrun
    );
endinterface

// File: rtl/adc_spi_sampler.sv
// Periodic MCP3201-style SPI ADC reader: frames a conversion, shifts in
// lead + data bits, and presents each result with a multi-cycle rdy strobe.
module adc_spi_sampler #(
    parameter int ADC_DATLEN    = 12,
    parameter int LEAD_BITS     = 3,
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int RDY_HOLD      = 2
) (
    input  logic               clk,
    input  logic               rst,
    adc_spi_sampler_if.master  bus
);
    localparam int NBITS = LEAD_BITS + ADC_DATLEN;
    localparam int PW    = $clog2(SAMPLE_PERIOD);
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int HW    = (RDY_HOLD > 1) ? $clog2(RDY_HOLD) : 1;

    localparam logic [PW-1:0] PER_LAST  = PW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(NBITS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RDY_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

    state_e                state_q, state_d;
    logic [PW-1:0]         per_q, per_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [NBITS-1:0]      shreg_q, shreg_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic [ADC_DATLEN-1:0] sample_q, sample_d;
    logic                  rdy_q, rdy_d;
    logic                  ovr_q, ovr_d;
    logic                  tick;

    assign tick = bus.en && (per_q == PER_LAST);

    // Free-running conversion-rate counter, parked at zero while disabled.
    always_comb begin
        per_d = '0;
        if (bus.en) begin
            per_d = (per_q == PER_LAST) ? '0 : per_q + PW'(1);
        end
    end

    // Conversion sequencer, SCLK generation, shifting and rdy hold-off.
    // rdy and sample are loaded on the final SCLK fall so the strobe is
    // already high during DONE; CS is released when DONE is left.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        hold_d   = hold_q;
        shreg_d  = shreg_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        sample_d = sample_q;
        rdy_d    = rdy_q;
        ovr_d    = ovr_q | (tick && (state_q != IDLE));

        if (rdy_q) begin
            if (hold_q == '0) begin
                rdy_d = 1'b0;
            end else begin
                hold_d = hold_q - HW'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                if (tick) begin
                    state_d = SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        shreg_d = {shreg_q[NBITS-2:0], bus.adc_miso};
                    end else begin
                        bit_d = bit_q + BW'(1);
                        if (bit_q == BIT_LAST) begin
                            state_d  = DONE;
                            sample_d = shreg_q[ADC_DATLEN-1:0];
                            rdy_d    = 1'b1;
                            hold_d   = HOLD_LAST;
                        end
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            DONE: begin
                cs_n_d  = 1'b1;
                sclk_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset to the idle, deselected state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            per_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            hold_q   <= '0;
            shreg_q  <= '0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            sample_q <= '0;
            rdy_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            hold_q   <= hold_d;
            shreg_q  <= shreg_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            sample_q <= sample_d;
            rdy_q    <= rdy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign bus.adc_cs_n = cs_n_q;
    assign bus.adc_sclk = sclk_q;
    assign bus.sample   = sample_q;
    assign bus.rdy      = rdy_q;
    assign bus.overrun  = ovr_q;
endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: two instances (slow and fast sample rate)
// driven by a frame-level ADC model; results compared against data words.
module tb_adc_spi_sampler;
    localparam int DL   = 12;
    localparam int LB   = 3;
    localparam int CD   = 4;
    localparam int RH   = 2;
    localparam int SP_A = 200;
    localparam int SP_B = 50;
    localparam int FL   = LB + DL;
    localparam int LAT  = CD + 2 * CD * FL + 1;
    localparam int GAP_B = ((LAT / SP_B) + 1) * SP_B + 1 - LAT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rdy_cyc = 0;
    int cslow_a = 0;
    int rises_a = 0;
    int rises_b = 0;
    int idx_a = 0;
    int idx_b = 0;
    logic [FL-1:0] frame_a = '0;
    logic [FL-1:0] frame_b = '0;
    logic [DL-1:0] store [16];

    adc_spi_sampler_if #(.ADC_DATLEN(DL)) ifa ();
    adc_spi_sampler_if #(.ADC_DATLEN(DL)) ifb ();

    adc_spi_sampler #(
        .ADC_DATLEN(DL), .LEAD_BITS(LB), .CLK_DIV(CD),
        .SAMPLE_PERIOD(SP_A), .RDY_HOLD(RH)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );

    adc_spi_sampler #(
        .ADC_DATLEN(DL), .LEAD_BITS(LB), .CLK_DIV(CD),
        .SAMPLE_PERIOD(SP_B), .RDY_HOLD(RH)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ifa.adc_cs_n === 1'b0) cslow_a <= cslow_a + 1;
    end

    // ADC models: first frame bit after CS falls, next bit after each SCLK fall.
    always @(negedge ifa.adc_cs_n) begin
        idx_a = 0;
        ifa.adc_miso = frame_a[FL-1];
    end
    always @(negedge ifa.adc_sclk) begin
        if (ifa.adc_cs_n === 1'b0) begin
            idx_a++;
            if (idx_a < FL) ifa.adc_miso = frame_a[FL-1-idx_a];
        end
    end
    always @(posedge ifa.adc_sclk) rises_a++;

    always @(negedge ifb.adc_cs_n) begin
        idx_b = 0;
        ifb.adc_miso = frame_b[FL-1];
    end
    always @(negedge ifb.adc_sclk) begin
        if (ifb.adc_cs_n === 1'b0) begin
            idx_b++;
            if (idx_b < FL) ifb.adc_miso = frame_b[FL-1-idx_b];
        end
    end
    always @(posedge ifb.adc_sclk) rises_b++;

    function automatic int rev4(input int v);
        int r = 0;
        for (int i = 0; i < 4; i++) if ((v & (1 << i)) != 0) r |= 1 << (3 - i);
        return r;
    endfunction

    task automatic wait_rdy_a(input int lim, output int n);
        n = 0;
        while (ifa.rdy !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (ifa.rdy !== 1'b1) n = -1;
    endtask

    task automatic wait_low_a(output int w);
        w = 0;
        while (ifa.rdy === 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.en = 1'b0;
        ifb.en = 1'b0;
        ifa.adc_miso = 1'b0;
        ifb.adc_miso = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ifa.adc_cs_n !== 1'b1) begin failures++;
            $display("FAIL reset_cs_n got=%b exp=1", ifa.adc_cs_n); end
        checks++; if (ifa.adc_sclk !== 1'b0) begin failures++;
            $display("FAIL reset_sclk got=%b exp=0", ifa.adc_sclk); end
        checks++; if (ifa.sample !== '0) begin failures++;
            $display("FAIL reset_sample got=%h exp=0", ifa.sample); end
        checks++; if (ifa.rdy !== 1'b0) begin failures++;
            $display("FAIL reset_rdy got=%b exp=0", ifa.rdy); end
        checks++; if (ifa.overrun !== 1'b0) begin failures++;
            $display("FAIL reset_overrun got=%b exp=0", ifa.overrun); end
        checks++; if (ifb.adc_cs_n !== 1'b1 || ifb.overrun !== 1'b0) begin failures++;
            $display("FAIL reset_b got=%b%b exp=10", ifb.adc_cs_n, ifb.overrun); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n, w, c0, r0;
        frame_a = {3'b111, 12'hA5C};
        c0 = cslow_a;
        r0 = rises_a;
        @(negedge clk);
        ifa.en = 1'b1;
        n = 0;
        while (ifa.adc_cs_n !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== SP_A) begin failures++;
            $display("FAIL first_tick got=%0d exp=%0d", n, SP_A); end
        wait_rdy_a(400, n);
        rdy_cyc = cyc;
        checks++; if (n + 1 !== LAT) begin failures++;
            $display("FAIL latency got=%0d exp=%0d", n + 1, LAT); end
        checks++; if (ifa.sample !== 12'hA5C) begin failures++;
            $display("FAIL single_sample got=%h exp=a5c", ifa.sample); end
        wait_low_a(w);
        checks++; if (w !== RH) begin failures++;
            $display("FAIL rdy_width got=%0d exp=%0d", w, RH); end
        checks++; if (cslow_a - c0 !== LAT) begin failures++;
            $display("FAIL cs_low_len got=%0d exp=%0d", cslow_a - c0, LAT); end
        checks++; if (rises_a - r0 !== FL) begin failures++;
            $display("FAIL sclk_rises got=%0d exp=%0d", rises_a - r0, FL); end
        checks++; if (ifa.overrun !== 1'b0) begin failures++;
            $display("FAIL single_overrun got=%b exp=0", ifa.overrun); end
    endtask

    task automatic test_sequence();
        int n, w, bad;
        for (int k = 0; k < 16; k++) begin
            frame_a = FL'($urandom_range(0, 7) * 4096 + k);
            wait_rdy_a(400, n);
            checks++; if (cyc - rdy_cyc !== SP_A) begin failures++;
                $display("FAIL seq_spacing k=%0d got=%0d exp=%0d", k, cyc - rdy_cyc, SP_A); end
            rdy_cyc = cyc;
            checks++; if (ifa.sample !== DL'(k)) begin failures++;
                $display("FAIL seq_sample k=%0d got=%h exp=%h", k, ifa.sample, k); end
            store[rev4(k)] = ifa.sample;
            wait_low_a(w);
        end
        bad = 0;
        for (int j = 0; j < 16; j++) if (store[j] !== DL'(rev4(j))) bad++;
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL store_order got=%0d bad slots exp=0", bad); end
    endtask

    task automatic test_extremes();
        int n, w;
        int lead [2];
        int data [2];
        lead[0] = 0;
        data[0] = 4095;
        lead[1] = 7;
        data[1] = 0;
        for (int k = 0; k < 2; k++) begin
            frame_a = FL'(lead[k] * 4096 + data[k]);
            wait_rdy_a(400, n);
            checks++; if (ifa.sample !== DL'(data[k])) begin failures++;
                $display("FAIL extreme_sample k=%0d got=%h exp=%h", k, ifa.sample, data[k]); end
            wait_low_a(w);
        end
    endtask

    task automatic test_random();
        int n, w, r0, data;
        for (int k = 0; k < 6; k++) begin
            data = int'($urandom_range(0, 4095));
            frame_a = FL'(int'($urandom_range(0, 7)) * 4096 + data);
            r0 = rises_a;
            wait_rdy_a(400, n);
            checks++; if (ifa.sample !== DL'(data)) begin failures++;
                $display("FAIL rand_sample k=%0d got=%h exp=%h", k, ifa.sample, data); end
            wait_low_a(w);
            checks++; if (rises_a - r0 !== FL) begin failures++;
                $display("FAIL rand_rises k=%0d got=%0d exp=%0d", k, rises_a - r0, FL); end
        end
    endtask

    task automatic test_en_drop();
        int n, w, r0, c0, pulses, data;
        data = int'($urandom_range(0, 4095));
        frame_a = FL'(int'($urandom_range(0, 7)) * 4096 + data);
        r0 = rises_a;
        n = 0;
        while (rises_a < r0 + 3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        ifa.en = 1'b0;
        wait_rdy_a(400, n);
        checks++; if (ifa.sample !== DL'(data) || n < 0) begin failures++;
            $display("FAIL endrop_sample got=%h exp=%h", ifa.sample, data); end
        wait_low_a(w);
        checks++; if (rises_a - r0 !== FL) begin failures++;
            $display("FAIL endrop_rises got=%0d exp=%0d", rises_a - r0, FL); end
        c0 = cslow_a;
        pulses = 0;
        repeat (3 * SP_A) begin
            @(negedge clk);
            if (ifa.rdy === 1'b1) pulses++;
        end
        checks++; if (cslow_a - c0 !== 0 || pulses !== 0) begin failures++;
            $display("FAIL endrop_idle got=%0d cs/%0d rdy exp=0/0", cslow_a - c0, pulses); end
    endtask

    task automatic test_rst_mid();
        int n, w, r0, c0, pulses, data;
        data = int'($urandom_range(0, 4095));
        frame_a = FL'(int'($urandom_range(0, 7)) * 4096 + data);
        r0 = rises_a;
        @(negedge clk);
        ifa.en = 1'b1;
        n = 0;
        while (rises_a < r0 + 7 && n < 600) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        ifa.en = 1'b0;
        @(negedge clk);
        checks++; if (ifa.adc_cs_n !== 1'b1 || ifa.adc_sclk !== 1'b0) begin failures++;
            $display("FAIL rst_pins got=%b%b exp=10", ifa.adc_cs_n, ifa.adc_sclk); end
        checks++; if (ifa.rdy !== 1'b0 || ifa.sample !== '0) begin failures++;
            $display("FAIL rst_out got=%b/%h exp=0/000", ifa.rdy, ifa.sample); end
        rst = 1'b0;
        c0 = cslow_a;
        pulses = 0;
        repeat (150) begin
            @(negedge clk);
            if (ifa.rdy === 1'b1) pulses++;
        end
        checks++; if (cslow_a - c0 !== 0 || pulses !== 0) begin failures++;
            $display("FAIL rst_quiet got=%0d cs/%0d rdy exp=0/0", cslow_a - c0, pulses); end
        data = int'($urandom_range(0, 4095));
        frame_a = FL'(int'($urandom_range(0, 7)) * 4096 + data);
        ifa.en = 1'b1;
        n = 0;
        while (ifa.adc_cs_n !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== SP_A) begin failures++;
            $display("FAIL rst_first_tick got=%0d exp=%0d", n, SP_A); end
        wait_rdy_a(400, n);
        checks++; if (n + 1 !== LAT || ifa.sample !== DL'(data)) begin failures++;
            $display("FAIL rst_next got=%0d/%h exp=%0d/%h", n + 1, ifa.sample, LAT, data); end
        ifa.en = 1'b0;
        wait_low_a(w);
    endtask

    task automatic test_overrun();
        int n, ovr_at, r0, d1, d2;
        d1 = int'($urandom_range(0, 4095));
        frame_b = FL'(int'($urandom_range(0, 7)) * 4096 + d1);
        r0 = rises_b;
        @(negedge clk);
        ifb.en = 1'b1;
        n = 0;
        while (ifb.adc_cs_n !== 1'b0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n !== SP_B) begin failures++;
            $display("FAIL ovr_first_tick got=%0d exp=%0d", n, SP_B); end
        n = 0;
        ovr_at = -1;
        while (ifb.rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (ovr_at < 0 && ifb.overrun === 1'b1) ovr_at = n;
        end
        checks++; if (ovr_at !== SP_B) begin failures++;
            $display("FAIL ovr_set_at got=%0d exp=%0d", ovr_at, SP_B); end
        checks++; if (n + 1 !== LAT || ifb.sample !== DL'(d1)) begin failures++;
            $display("FAIL ovr_first got=%0d/%h exp=%0d/%h", n + 1, ifb.sample, LAT, d1); end
        checks++; if (rises_b - r0 !== FL) begin failures++;
            $display("FAIL ovr_rises got=%0d exp=%0d", rises_b - r0, FL); end
        d2 = int'($urandom_range(0, 4095));
        frame_b = FL'(int'($urandom_range(0, 7)) * 4096 + d2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifb.adc_cs_n !== 1'b0 && n < 400);
        checks++; if (n !== GAP_B) begin failures++;
            $display("FAIL ovr_no_queue got=%0d exp=%0d", n, GAP_B); end
        ifb.en = 1'b0;
        n = 0;
        while (ifb.rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++; if (ifb.sample !== DL'(d2) || ifb.overrun !== 1'b1) begin failures++;
            $display("FAIL ovr_second got=%h/%b exp=%h/1", ifb.sample, ifb.overrun, d2); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sequence();
        test_extremes();
        test_random();
        test_en_drop();
        test_rst_mid();
        test_overrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_spi_sampler.md
Name: adc_spi_sampler

Overview:
- Upstream acquisition stage for the 16-point DIT sample store.
- Periodically runs a serial conversion on an external 12-bit SPI ADC (MCP3201-style: two sample clocks plus a null bit, then 12 data bits MSB-first).
- Assembles each result and presents it on `sample`, with a multi-cycle `rdy` strobe that the bit-reversing store latches on its rising edge.
- Also generates `adc_cs_n` and `adc_sclk`, and flags sample-rate overruns.

Parameters:
- ADC_DATLEN, 12: data bits per conversion; width of `sample`.
- LEAD_BITS, 3: leading SCLK cycles before the MSB, discarded.
- CLK_DIV, 4: clk cycles per SCLK half-period; also the CS-to-first-edge setup time. Must be ≥1.
- SAMPLE_PERIOD, 1000: clk cycles between conversion starts. Must be ≥2.
- RDY_HOLD, 2: clk cycles that `rdy` stays high per sample. Must be ≥1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: acquisition enable.
- adc_miso, input, 1: ADC serial data out; already synchronised externally.
- adc_cs_n, output, 1: ADC chip select, active low.
- adc_sclk, output, 1: ADC serial clock; idles low.
- sample, output, ADC_DATLEN: last completed conversion, MSB = ADC bit 11.
- rdy, output, 1: new-sample strobe to the store's rdy input.
- overrun, output, 1: sticky; a period tick arrived while a conversion was still busy.

Behaviour:
- Reset values:
  - adc_cs_n=1, adc_sclk=0, sample=0, rdy=0, overrun=0.
  - FSM=IDLE; period, half-period, bit and hold counters=0; shift register=0.
- Period counter:
  - While en=1, counts 0..SAMPLE_PERIOD-1 and wraps.
  - tick is asserted in the cycle the count equals SAMPLE_PERIOD-1.
  - While en=0, the counter is held at 0 and no tick occurs.
  - The first tick comes SAMPLE_PERIOD cycles after en rises.
- FSM states: IDLE, SETUP, SHIFT, DONE.
  - IDLE: adc_cs_n=1, adc_sclk=0.
    - tick → SETUP; adc_cs_n goes low on the same edge.
  - SETUP: hold adc_cs_n=0, adc_sclk=0 for CLK_DIV cycles, then → SHIFT.
  - SHIFT: adc_sclk toggles every CLK_DIV cycles, starting low.
    - On each cycle where adc_sclk goes 0→1, shift adc_miso into the LSB of the shift register.
    - Exactly LEAD_BITS+ADC_DATLEN rising edges per conversion (15 by default).
    - After the final falling edge → DONE.
  - DONE (one cycle):
    - adc_cs_n=1, adc_sclk=0.
    - sample ← low ADC_DATLEN bits of the shift register; lead bits are discarded regardless of value.
    - rdy←1; hold counter loaded.
    - → IDLE.
- rdy timing:
  - rdy remains 1 for exactly RDY_HOLD cycles, then 0.
  - sample is stable whenever rdy=1 and until the next DONE.
- Latency: rdy rises CLK_DIV + 2·CLK_DIV·(LEAD_BITS+ADC_DATLEN) + 1 cycles after the tick cycle. Default: 125 cycles.
- Overrun:
  - A tick in any state other than IDLE sets overrun=1 and is otherwise dropped; the conversion in progress is unaffected.
  - overrun clears only on rst.
- en deassertion:
  - en falling mid-conversion does not abort; the conversion completes with a normal rdy pulse.
  - No further conversions start while en=0.
- rst mid-operation:
  - On the next edge, adc_cs_n=1, adc_sclk=0, rdy=0, FSM=IDLE.
  - The partial word is discarded and sample returns to 0.
- A new DONE occurring while rdy is still high is impossible, because SAMPLE_PERIOD > RDY_HOLD is implied by the conversion length. It needs no handling.

Test Plan:
- en=1, SAMPLE_PERIOD=200, ADC model shifts lead bits 1,1,1 then 0xA5C → sample=0xA5C, rdy high exactly 2 cycles, 15 SCLK rising edges seen, adc_cs_n low 125 cycles, overrun=0.
- 16 consecutive conversions, model returns 0x000..0x00F → 16 rdy pulses exactly 200 cycles apart; sample values in order; the downstream store receives all 16 in bit-reversed slots.
- SAMPLE_PERIOD=50 → overrun=1 at the second tick; the first conversion still completes with its correct value; ticks are never queued.
- rst pulsed at the 7th SCLK rising edge → next cycle adc_cs_n=1, adc_sclk=0, no rdy; sample=0; the next conversion after en is normal.
- en dropped during SHIFT → the conversion completes, rdy pulses once, then adc_cs_n stays high for ≥3·SAMPLE_PERIOD cycles.
- Model drives all-ones (0xFFF) then all-zeros (0x000) → sample=0xFFF then 0x000; lead-bit values do not affect sample.
